// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/decode controls in, instruction-memory address out,
// and the IF/ID register contents delivered to decode.
interface fetch_stage_if;
  logic        stall_f;
  logic        flush_d;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        valid_d;
  logic        fault_d;
  logic [31:0] fetch_cnt;

  // Surrounding pipeline, hazard unit and instruction memory
  modport master (
    output stall_f, flush_d, redir_valid, redir_target, instr_f,
    input  pc_f, instr_d, pc_d, pc8_d, valid_d, fault_d, fetch_cnt
  );

  // Fetch stage itself
  modport slave (
    input  stall_f, flush_d, redir_valid, redir_target, instr_f,
    output pc_f, instr_d, pc_d, pc8_d, valid_d, fault_d, fetch_cnt
  );
endinterface

// File: rtl/fetch_stage.sv
// PC generation and IF/ID register for the P5 MIPS core (delay-slot fetch,
// stall/flush, decode redirects buffered across stalls, fault tagging).
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_3000,
  parameter int unsigned IM_ADDR_BITS = 10
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.slave  bus
);

  localparam int unsigned XLEN     = 32;
  localparam logic [32:0] IM_BYTES = 33'(4) << IM_ADDR_BITS;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pend_target;
  logic            r_pend;
  logic [XLEN-1:0] r_instr_d;
  logic [XLEN-1:0] r_pc_d;
  logic [XLEN-1:0] r_pc8_d;
  logic            r_valid_d;
  logic            r_fault_d;
  logic [XLEN-1:0] r_fetch_cnt;

  logic [XLEN-1:0] w_pc_off;
  logic            w_fault_f;
  logic [XLEN-1:0] w_next_pc;

  // Fault on misaligned PC or PC outside the instruction-memory window
  always_comb begin
    w_pc_off  = r_pc - RESET_PC;
    w_fault_f = (r_pc[1:0] != 2'b00) || ({1'b0, w_pc_off} >= IM_BYTES);
  end

  // A live redirect takes priority over one buffered during a stall
  always_comb begin
    w_next_pc = r_pc + XLEN'(4);
    if (bus.redir_valid) begin
      w_next_pc = bus.redir_target;
    end else if (r_pend) begin
      w_next_pc = r_pend_target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_pend        <= 1'b0;
      r_pend_target <= '0;
      r_instr_d     <= '0;
      r_pc_d        <= '0;
      r_pc8_d       <= '0;
      r_valid_d     <= 1'b0;
      r_fault_d     <= 1'b0;
      r_fetch_cnt   <= '0;
    end else begin
      if (!bus.stall_f) begin
        r_pc   <= w_next_pc;
        r_pend <= 1'b0;
      end else if (bus.redir_valid) begin
        r_pend        <= 1'b1;
        r_pend_target <= bus.redir_target;
      end

      // Flush inserts a nop bubble even while the stage is stalled
      if (bus.flush_d) begin
        r_instr_d <= '0;
        r_pc_d    <= '0;
        r_pc8_d   <= '0;
        r_valid_d <= 1'b0;
        r_fault_d <= 1'b0;
      end else if (!bus.stall_f) begin
        r_instr_d   <= w_fault_f ? '0 : bus.instr_f;
        r_pc_d      <= r_pc;
        r_pc8_d     <= r_pc + XLEN'(8);
        r_valid_d   <= 1'b1;
        r_fault_d   <= w_fault_f;
        r_fetch_cnt <= r_fetch_cnt + XLEN'(1);
      end
    end
  end

  assign bus.pc_f      = r_pc;
  assign bus.instr_d   = r_instr_d;
  assign bus.pc_d      = r_pc_d;
  assign bus.pc8_d     = r_pc8_d;
  assign bus.valid_d   = r_valid_d;
  assign bus.fault_d   = r_fault_d;
  assign bus.fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then
// random stall/flush/redirect traffic checked every cycle against a model.
module tb_fetch_stage;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_3000), .IM_ADDR_BITS(10)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a nonzero word derived from the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) | 32'h1;
  endfunction

  assign bus.instr_f = mem_word(bus.pc_f);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural state kept as plain variables
  logic [31:0] m_pc, m_pend_tgt, m_instr, m_pcd, m_pc8, m_cnt;
  bit          m_pend, m_valid, m_fault;

  function automatic bit bad_addr(input logic [31:0] a);
    longint unsigned u;
    u = longint'(a);
    return (a % 4 != 0) || (u < 64'h3000) || (u >= 64'h3000 + 4 * 1024);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] npc;
    bit          f;
    if (!rst_n) begin
      m_pc = 32'h3000; m_pend = 0; m_pend_tgt = 0;
      m_instr = 0; m_pcd = 0; m_pc8 = 0; m_valid = 0; m_fault = 0; m_cnt = 0;
    end else begin
      npc = bus.redir_valid ? bus.redir_target : (m_pend ? m_pend_tgt : m_pc + 4);
      f   = bad_addr(m_pc);
      if (bus.flush_d) begin
        m_instr = 0; m_pcd = 0; m_pc8 = 0; m_valid = 0; m_fault = 0;
      end else if (!bus.stall_f) begin
        m_instr = f ? 32'h0 : mem_word(m_pc);
        m_pcd = m_pc; m_pc8 = m_pc + 8; m_valid = 1; m_fault = f; m_cnt = m_cnt + 1;
      end
      if (!bus.stall_f) begin
        m_pc = npc; m_pend = 0;
      end else if (bus.redir_valid) begin
        m_pend = 1; m_pend_tgt = bus.redir_target;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("pc_f",      bus.pc_f,      m_pc);
    chk("instr_d",   bus.instr_d,   m_instr);
    chk("pc_d",      bus.pc_d,      m_pcd);
    chk("pc8_d",     bus.pc8_d,     m_pc8);
    chk("valid_d",   32'(bus.valid_d), 32'(m_valid));
    chk("fault_d",   32'(bus.fault_d), 32'(m_fault));
    chk("fetch_cnt", bus.fetch_cnt, m_cnt);
  end

  // Drive one cycle of inputs (called just after a negedge), return at next negedge
  task automatic tick(input bit st, input bit fl, input bit rv, input logic [31:0] rt);
    bus.stall_f = st; bus.flush_d = fl; bus.redir_valid = rv; bus.redir_target = rt;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] tgt;
    n_cmp = 0; n_mis = 0;
    rst_n = 1'b0;
    bus.stall_f = 0; bus.flush_d = 0; bus.redir_valid = 0; bus.redir_target = 0;
    repeat (2) @(negedge clk);
    chk("rst_pc_f", bus.pc_f, 32'h3000);
    chk("rst_valid", 32'(bus.valid_d), 32'd0);
    chk("rst_cnt", bus.fetch_cnt, 32'd0);
    rst_n = 1'b1;

    // Sequential fetch after reset release
    tick(0, 0, 0, 0);
    chk("t1_pc_f", bus.pc_f, 32'h3004);
    chk("t1_pc_d", bus.pc_d, 32'h3000);
    chk("t1_pc8_d", bus.pc8_d, 32'h3008);
    chk("t1_instr", bus.instr_d, mem_word(32'h3000));
    chk("t1_valid", 32'(bus.valid_d), 32'd1);
    chk("t1_cnt", bus.fetch_cnt, 32'd1);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("t1_pc_f3", bus.pc_f, 32'h300C);
    chk("t1_cnt3", bus.fetch_cnt, 32'd3);

    // Redirect keeps the delay slot
    tick(0, 0, 1, 32'h3100);
    chk("t2_pc_f", bus.pc_f, 32'h3100);
    chk("t2_pc_d", bus.pc_d, 32'h300C);

    // Redirect arriving during a stall is buffered
    tick(1, 0, 0, 0);
    tick(1, 0, 1, 32'h3200);
    tick(1, 0, 0, 0);
    chk("t3_pc_f_frz", bus.pc_f, 32'h3100);
    chk("t3_pc_d_frz", bus.pc_d, 32'h300C);
    chk("t3_cnt_frz", bus.fetch_cnt, 32'd4);
    tick(0, 0, 0, 0);
    chk("t3_pc_f", bus.pc_f, 32'h3200);
    chk("t3_pc_d", bus.pc_d, 32'h3100);

    // Flush with and without stall
    tick(1, 1, 0, 0);
    chk("t4_instr", bus.instr_d, 32'h0);
    chk("t4_valid", 32'(bus.valid_d), 32'd0);
    chk("t4_pc_f", bus.pc_f, 32'h3200);
    tick(0, 1, 0, 0);
    chk("t4_pc_f2", bus.pc_f, 32'h3204);
    chk("t4_cnt", bus.fetch_cnt, 32'd5);

    // Faulting fetch addresses: misaligned and beyond memory
    tick(0, 0, 1, 32'h3002);
    tick(0, 0, 0, 0);
    chk("t5_pc_d", bus.pc_d, 32'h3002);
    chk("t5_instr", bus.instr_d, 32'h0);
    chk("t5_fault", 32'(bus.fault_d), 32'd1);
    chk("t5_valid", 32'(bus.valid_d), 32'd1);
    tick(0, 0, 1, 32'h4000);
    chk("t5_pc_d2", bus.pc_d, 32'h3006);
    chk("t5_fault2", 32'(bus.fault_d), 32'd1);
    tick(0, 0, 0, 0);
    chk("t5_pc_d3", bus.pc_d, 32'h4000);
    chk("t5_fault3", 32'(bus.fault_d), 32'd1);
    chk("t5_cnt", bus.fetch_cnt, 32'd9);

    // Randomized traffic; the compare process checks every cycle
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0:       tgt = $urandom;
        1:       tgt = 32'h3000 + 32'($urandom_range(0, 4095));
        default: tgt = 32'h3000 + 4 * 32'($urandom_range(0, 1023));
      endcase
      tick($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 20, tgt);
    end

    // Async reset mid-stall with a pending redirect
    tick(1, 0, 1, 32'h3300);
    bus.stall_f = 1; bus.redir_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_pc_f", bus.pc_f, 32'h3000);
    chk("t6_pc_d", bus.pc_d, 32'h0);
    chk("t6_instr", bus.instr_d, 32'h0);
    chk("t6_valid", 32'(bus.valid_d), 32'd0);
    chk("t6_cnt", bus.fetch_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(0, 0, 0, 0);
    chk("t6_pc_f2", bus.pc_f, 32'h3004);
    chk("t6_pc_d2", bus.pc_d, 32'h3000);
    tick(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
